// File: rtl/my_counter_pkg.sv
// Shared types and elaboration helpers for the my_counter up/down counter.
package my_counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Prescaler register width; a divide-by-one prescaler still keeps one bit.
    function automatic int cnt_width(input int div);
        return (div > 32'sd1) ? $clog2(div) : 32'sd1;
    endfunction

endpackage

// File: rtl/my_counter_tick.sv
// Prescaler: counts 0..TICK_DIV-1 and raises a one-cycle registered tick on the terminal count.
module my_counter_tick
    import my_counter_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int            CW       = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST     = CW'(TICK_DIV - 1);
    localparam logic          TICK_RST = (TICK_DIV == 1) ? 1'b1 : 1'b0;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          tick_r;

    // Next prescaler count, wrapping to zero after the terminal count.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_r == LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Prescaler state; tick is registered so it is high exactly while cnt_r sits at the terminal count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_r  <= '0;
            tick_r <= TICK_RST;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/my_counter.sv
// Up/down LED counter with synchronized direction input and reset release, stepping on prescaler ticks.
module my_counter
    import my_counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DIR,
    output logic [WIDTH-1:0] LED
);

    logic             rst_meta_r;
    logic             rst_sync_r;
    logic             dir_meta_r;
    dir_e             dir_s;
    logic             tick_s;
    logic [WIDTH-1:0] led_r;
    logic [WIDTH-1:0] led_nxt_s;

    // Reset synchronizer: asserts immediately, releases two edges after RST rises.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Two-flop synchronizer for the asynchronous direction input.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dir_meta_r <= 1'b0;
            dir_s      <= DIR_UP;
        end else begin
            dir_meta_r <= DIR;
            dir_s      <= dir_e'(dir_meta_r);
        end
    end

    my_counter_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK  (CLK),
        .RST  (rst_sync_r),
        .tick (tick_s)
    );

    // Next counter value: direction is only consulted on a tick; otherwise hold.
    always_comb begin
        led_nxt_s = led_r;
        if (tick_s) begin
            case (dir_s)
                DIR_UP:   led_nxt_s = led_r + WIDTH'(1);
                DIR_DOWN: led_nxt_s = led_r - WIDTH'(1);
                default:  led_nxt_s = led_r;
            endcase
        end else begin
            led_nxt_s = led_r;
        end
    end

    // Counter register; cleared asynchronously whenever the synchronized reset drops.
    always_ff @(posedge CLK or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            led_r <= '0;
        end else begin
            led_r <= led_nxt_s;
        end
    end

    assign LED = led_r;

endmodule

// File: tb/tb_my_counter.sv
// Directed bench for my_counter: one divide-by-1 and one divide-by-4 instance on a shared clock and reset.
module tb_my_counter;

    logic       clk;
    logic       rst;
    logic       dir1;
    logic       dir4;
    logic [2:0] led1;
    logic [2:0] led4;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected LED values after edges 1..34 following reset release.
    logic [2:0] exp1 [34] = '{
        3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2,
        3'd1, 3'd0, 3'd1, 3'd2
    };
    logic [2:0] exp4 [34] = '{
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2,
        3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2,
        3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7,
        3'd7, 3'd7, 3'd7, 3'd0
    };
    // Restart after the mid-cycle reset, edges 1..6 after release.
    logic [2:0] rexp1 [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0] rexp4 [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};

    my_counter #(
        .WIDTH    (3),
        .TICK_DIV (1)
    ) dut1 (
        .CLK (clk),
        .RST (rst),
        .DIR (dir1),
        .LED (led1)
    );

    my_counter #(
        .WIDTH    (3),
        .TICK_DIV (4)
    ) dut4 (
        .CLK (clk),
        .RST (rst),
        .DIR (dir4),
        .LED (led4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b0;
        dir1 = 1'b0;
        dir4 = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_hold1_c%0d", i), led1, 3'd0);
            chk($sformatf("rst_hold4_c%0d", i), led4, 3'd0);
        end

        rst = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("led1_e%0d", k), led1, exp1[k-1]);
            chk($sformatf("led4_e%0d", k), led4, exp4[k-1]);
            if (k == 15) begin
                dir1 = 1'b1;
                dir4 = 1'b1;
            end
            if (k == 30) dir1 = 1'b0;
            if (k == 31) dir4 = 1'b0;
        end

        #2;
        rst = 1'b0;
        #1;
        chk("midcycle_rst1", led1, 3'd0);
        chk("midcycle_rst4", led4, 3'd0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst2_hold1_c%0d", i), led1, 3'd0);
            chk($sformatf("rst2_hold4_c%0d", i), led4, 3'd0);
        end

        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("restart1_e%0d", k), led1, rexp1[k-1]);
            chk($sformatf("restart4_e%0d", k), led4, rexp4[k-1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
